// File: rtl/mdu_hilo.sv
// Iterative 32-bit multiply/divide unit with architectural HI/LO registers.
// One radix-2 step per cycle: shift-add multiply, restoring divide, sign fix-up at the end.
module mdu_hilo (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_start,
  input  logic [1:0]  i_op,
  input  logic [31:0] i_a,
  input  logic [31:0] i_b,
  input  logic        i_mthi,
  input  logic        i_mtlo,
  input  logic [31:0] i_wdata,
  output logic        o_busy,
  output logic        o_done,
  output logic [31:0] o_hi,
  output logic [31:0] o_lo
);

  typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

  state_e      r_state, w_state_d;
  logic [1:0]  r_op, w_op_d;
  logic [5:0]  r_cnt, w_cnt_d;
  logic [63:0] r_acc, w_acc_d;
  logic [31:0] r_opb, w_opb_d;
  logic [31:0] r_a, w_a_d;
  logic        r_neg_q, w_neg_q_d;
  logic        r_neg_r, w_neg_r_d;
  logic        r_bzero, w_bzero_d;
  logic [31:0] r_hi, w_hi_d;
  logic [31:0] r_lo, w_lo_d;
  logic        r_busy, w_busy_d;
  logic        r_done, w_done_d;

  logic        w_signed;
  logic [31:0] w_amag, w_bmag;
  logic [32:0] w_madd, w_mupper;
  logic [63:0] w_mul_next;
  logic [33:0] w_trial;
  logic        w_nb;
  logic [63:0] w_div_next;
  logic [63:0] w_prod;
  logic [31:0] w_quo, w_rem;

  assign w_signed = ~i_op[0];
  assign w_amag   = (w_signed && i_a[31]) ? 32'd0 - i_a : i_a;
  assign w_bmag   = (w_signed && i_b[31]) ? 32'd0 - i_b : i_b;

  // Multiply: acc = {partial product, remaining multiplier bits}; add on LSB, then shift right.
  assign w_madd     = {1'b0, r_acc[63:32]} + {1'b0, r_opb};
  assign w_mupper   = r_acc[0] ? w_madd : {1'b0, r_acc[63:32]};
  assign w_mul_next = {w_mupper, r_acc[31:1]};

  // Divide: the shifted partial remainder needs 33 bits, so trial-subtract from acc[63:31].
  assign w_trial    = {1'b0, r_acc[63:31]} - {2'b00, r_opb};
  assign w_nb       = ~w_trial[33];
  assign w_div_next = {(w_nb ? w_trial[31:0] : r_acc[62:31]), r_acc[30:0], w_nb};

  assign w_prod = r_neg_q ? 64'd0 - r_acc : r_acc;
  assign w_quo  = r_neg_q ? 32'd0 - r_acc[31:0] : r_acc[31:0];
  assign w_rem  = r_neg_r ? 32'd0 - r_acc[63:32] : r_acc[63:32];

  always_comb begin
    w_state_d = r_state;
    w_op_d    = r_op;
    w_cnt_d   = r_cnt;
    w_acc_d   = r_acc;
    w_opb_d   = r_opb;
    w_a_d     = r_a;
    w_neg_q_d = r_neg_q;
    w_neg_r_d = r_neg_r;
    w_bzero_d = r_bzero;
    w_hi_d    = r_hi;
    w_lo_d    = r_lo;
    w_busy_d  = r_busy;
    w_done_d  = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (i_start) begin
          w_op_d    = i_op;
          w_acc_d   = {32'd0, (i_op[1] ? w_amag : w_bmag)};
          w_opb_d   = i_op[1] ? w_bmag : w_amag;
          w_a_d     = i_a;
          w_neg_q_d = w_signed & (i_a[31] ^ i_b[31]);
          w_neg_r_d = w_signed & i_a[31];
          w_bzero_d = (i_b == 32'd0);
          w_cnt_d   = 6'd0;
          w_busy_d  = 1'b1;
          w_state_d = StRun;
        end else begin
          if (i_mthi) w_hi_d = i_wdata;
          if (i_mtlo) w_lo_d = i_wdata;
        end
      end
      StRun: begin
        w_acc_d = r_op[1] ? w_div_next : w_mul_next;
        w_cnt_d = r_cnt + 6'd1;
        if (r_cnt == 6'd31) w_state_d = StFix;
      end
      StFix: begin
        if (!r_op[1]) begin
          {w_hi_d, w_lo_d} = w_prod;
        end else if (r_bzero) begin
          w_hi_d = r_a;
          w_lo_d = 32'hFFFF_FFFF;
        end else begin
          w_hi_d = w_rem;
          w_lo_d = w_quo;
        end
        w_done_d  = 1'b1;
        w_busy_d  = 1'b0;
        w_state_d = StIdle;
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= StIdle;
      r_op    <= 2'b00;
      r_cnt   <= 6'd0;
      r_acc   <= 64'd0;
      r_opb   <= 32'd0;
      r_a     <= 32'd0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_bzero <= 1'b0;
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_op    <= w_op_d;
      r_cnt   <= w_cnt_d;
      r_acc   <= w_acc_d;
      r_opb   <= w_opb_d;
      r_a     <= w_a_d;
      r_neg_q <= w_neg_q_d;
      r_neg_r <= w_neg_r_d;
      r_bzero <= w_bzero_d;
      r_hi    <= w_hi_d;
      r_lo    <= w_lo_d;
      r_busy  <= w_busy_d;
      r_done  <= w_done_d;
    end
  end

  assign o_busy = r_busy;
  assign o_done = r_done;
  assign o_hi   = r_hi;
  assign o_lo   = r_lo;

endmodule
